// File: rtl/progmem_arbiter.sv
// progmem_arbiter: shares one single-port program memory between the CPU
// instruction-fetch port and the load/debug port. Fetch has priority; a
// starvation counter forces a load slot after STARVE_MAX fetch grants in a
// row while a load request is waiting. Read words are registered (latency 1).
// Optional feature macro: PM_WRPROTECT_EN rejects load-port writes to
// addresses below PROT_LIMIT and reports them on ld_err.
module progmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4,
  parameter int PROT_LIMIT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [DW-1:0] fetch_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       starved;
  logic       wr_blocked;

`ifdef PM_WRPROTECT_EN
  localparam logic [AW:0] PROT_LIM = (AW+1)'(PROT_LIMIT);
  assign wr_blocked = ({1'b0, ld_addr} < PROT_LIM);
`else
  assign wr_blocked = 1'b0;
`endif

  // Arbitration: forced load slot when starved, else fetch first, else load.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    starved   = ld_req && (starve_cnt == STARVE_TOP);
    if (!rst) begin
      if (starved)        ld_gnt    = 1'b1;
      else if (fetch_req) fetch_gnt = 1'b1;
      else if (ld_req)    ld_gnt    = 1'b1;
    end
  end

  // Memory drive follows the winner; fetch address parks on the bus when idle.
  always_comb begin
    mem_addr  = ld_gnt ? ld_addr : fetch_addr;
    mem_en    = fetch_gnt | ld_gnt;
    mem_we    = ld_gnt & ld_we & ~wr_blocked;
    mem_wdata = ld_wdata;
  end

  // Counts fetch grants taken while a load is waiting; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (ld_gnt || !ld_req) begin
      starve_cnt <= 4'd0;
    end else if (fetch_gnt && (starve_cnt != STARVE_TOP)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Registers the memory read word back to whichever port was granted a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_rvalid <= 1'b0;
      fetch_rdata  <= '0;
      ld_rvalid    <= 1'b0;
      ld_rdata     <= '0;
    end else begin
      fetch_rvalid <= fetch_gnt;
      if (fetch_gnt) fetch_rdata <= mem_rdata;
      ld_rvalid <= ld_gnt & ~ld_we;
      if (ld_gnt && !ld_we) ld_rdata <= mem_rdata;
    end
  end

`ifdef PM_WRPROTECT_EN
  // One-cycle error pulse after a rejected (protected) load write.
  always_ff @(posedge clk) begin
    if (rst) ld_err <= 1'b0;
    else     ld_err <= ld_gnt & ld_we & wr_blocked;
  end
`else
  assign ld_err = 1'b0;
`endif

endmodule

// File: tb/tb_progmem_arbiter.sv
// Scoreboard bench for progmem_arbiter: a reference arbiter/memory model
// predicts grants and read data, queues expected read responses, and a
// separate monitor pops and compares them when rvalid is seen.
module tb_progmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int SM = 4;
  localparam int PL = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt, fetch_rvalid;
  logic [DW-1:0] fetch_rdata;
  logic          ld_req = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_gnt, ld_rvalid, ld_err;
  logic [DW-1:0] ld_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_en, mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  progmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM), .PROT_LIMIT(PL)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  // physical memory attached to the DUT
  logic [DW-1:0] mem [0:255];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [DW-1:0] ref_mem [0:255];
  int  streak = 0;
  bit  last_f_gnt = 1'b0, last_l_gnt = 1'b0;
  int  mem_we_cnt = 0, f_rv_cnt = 0;

  typedef struct { logic [DW-1:0] data; int stamp; } exp_t;
  exp_t fq[$];
  exp_t lq[$];
  int   errq[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit prot(input logic [AW-1:0] a);
`ifdef PM_WRPROTECT_EN
    return (int'(a) < PL);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: judge the grant cycle at negedge, update the model, return after posedge.
  task automatic step();
    bit ef, el, wr, blk;
    @(negedge clk);
    ef = 1'b0;
    el = 1'b0;
    if (!rst) begin
      if (ld_req && (streak == SM || !fetch_req)) el = 1'b1;
      else if (fetch_req)                         ef = 1'b1;
    end
    blk = el && ld_we && prot(ld_addr);
    wr  = el && ld_we && !blk;
    chk("fetch_gnt", 32'(fetch_gnt), 32'(ef));
    chk("ld_gnt", 32'(ld_gnt), 32'(el));
    chk("mem_en", 32'(mem_en), 32'(ef | el));
    chk("mem_we", 32'(mem_we), 32'(wr));
    if (ef) chk("mem_addr_fetch", 32'(mem_addr), 32'(fetch_addr));
    if (el) chk("mem_addr_ld", 32'(mem_addr), 32'(ld_addr));
    if (wr) chk("mem_wdata", 32'(mem_wdata), 32'(ld_wdata));
    if (mem_we) mem_we_cnt++;
    if (ef) fq.push_back('{data: ref_mem[fetch_addr], stamp: cyc});
    if (el && !ld_we) lq.push_back('{data: ref_mem[ld_addr], stamp: cyc});
    if (wr) ref_mem[ld_addr] = ld_wdata;
    if (blk) errq.push_back(cyc);
    if (rst || el || !ld_req) streak = 0;
    else if (ef && streak < SM) streak++;
    last_f_gnt = fetch_gnt;
    last_l_gnt = ld_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit is_ld);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      step();
      got = is_ld ? last_l_gnt : last_f_gnt;
      n++;
    end
    chk(is_ld ? "ld_gnt_wait" : "fetch_gnt_wait", 32'(got), 32'd1);
  endtask

  // Monitor: pops expected read words when their response is due.
  logic [DW-1:0] f_hold = '0, l_hold = '0;
  always @(negedge clk) begin
    bit fdue, ldue, edue;
    fdue = (fq.size() > 0) && (fq[0].stamp == cyc - 1);
    ldue = (lq.size() > 0) && (lq[0].stamp == cyc - 1);
    edue = (errq.size() > 0) && (errq[0] == cyc - 1);
    chk("fetch_rvalid", 32'(fetch_rvalid), 32'(fdue));
    if (fdue) begin
      if (fetch_rvalid) chk("fetch_rdata", 32'(fetch_rdata), 32'(fq[0].data));
      f_hold = fq[0].data;
      void'(fq.pop_front());
    end else begin
      chk("fetch_rdata_hold", 32'(fetch_rdata), 32'(f_hold));
    end
    if (fetch_rvalid) f_rv_cnt++;
    chk("ld_rvalid", 32'(ld_rvalid), 32'(ldue));
    if (ldue) begin
      if (ld_rvalid) chk("ld_rdata", 32'(ld_rdata), 32'(lq[0].data));
      l_hold = lq[0].data;
      void'(lq.pop_front());
    end else begin
      chk("ld_rdata_hold", 32'(ld_rdata), 32'(l_hold));
    end
    chk("ld_err", 32'(ld_err), 32'(edue));
    if (edue) void'(errq.pop_front());
    if (rst) begin
      f_hold = '0;
      l_hold = '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [DW-1:0] saved;
    bit pat_got [10];
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end

    // reset with both requests asserted: nothing may be granted
    fetch_req = 1'b1; fetch_addr = 8'h10;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h40; ld_wdata = 16'h5555;
    repeat (3) step();
    chk("rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("rst_fetch_rdata", 32'(fetch_rdata), 32'd0);
    chk("rst_ld_rdata", 32'(ld_rdata), 32'd0);
    chk("rst_ld_err", 32'(ld_err), 32'd0);
    fetch_req = 1'b0; ld_req = 1'b0; rst = 1'b0;
    step();

    // back-to-back fetch 0x10..0x13
    base = f_rv_cnt;
    fetch_req = 1'b1;
    for (int a = 16; a < 20; a++) begin
      fetch_addr = 8'(a);
      wait_gnt(1'b0);
    end
    fetch_req = 1'b0;
    step(); step();
    chk("fetch_rvalid_count", 32'(f_rv_cnt - base), 32'd4);

    // load write then read back
    base = mem_we_cnt;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h20; ld_wdata = 16'hBEEF;
    wait_gnt(1'b1);
    ld_we = 1'b0;
    wait_gnt(1'b1);
    ld_req = 1'b0;
    step(); step();
    chk("ld_write_count", 32'(mem_we_cnt - base), 32'd1);
    chk("ld_readback", 32'(ld_rdata), 32'hBEEF);
    chk("mem_20", 32'(mem[8'h20]), 32'hBEEF);

    // both held: fetch gets SM slots, then load
    fetch_req = 1'b1; fetch_addr = 8'h08;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h21;
    for (int i = 0; i < 10; i++) begin
      step();
      pat_got[i] = last_l_gnt;
      fetch_addr = 8'(i);
    end
    for (int i = 0; i < 10; i++)
      chk("starve_pattern", 32'(pat_got[i]), 32'(((i + 1) % (SM + 1)) == 0));
    fetch_req = 1'b0; ld_req = 1'b0;
    step(); step();

`ifdef PM_WRPROTECT_EN
    saved = mem[8'h05];
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h05; ld_wdata = 16'h1234;
    wait_gnt(1'b1);
    ld_we = 1'b0;
    wait_gnt(1'b1);
    ld_we = 1'b1; ld_addr = 8'h30; ld_wdata = 16'hCAFE;
    wait_gnt(1'b1);
    ld_req = 1'b0;
    step(); step();
    chk("prot_mem_05", 32'(mem[8'h05]), 32'(saved));
    chk("prot_mem_30", 32'(mem[8'h30]), 32'hCAFE);
`else
    saved = '0;
`endif

    // reset the cycle after a fetch grant
    fetch_req = 1'b1; fetch_addr = 8'h40;
    wait_gnt(1'b0);
    fetch_req = 1'b0;
    rst = 1'b1;
    step(); step();
    chk("post_rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("post_rst_fetch_rdata", 32'(fetch_rdata), 32'd0);
    rst = 1'b0;
    step();
    fetch_req = 1'b1; fetch_addr = 8'h00;
    wait_gnt(1'b0);
    fetch_req = 1'b0;
    chk("post_rst_fetch0_valid", 32'(fetch_rvalid), 32'd1);
    chk("post_rst_fetch0_data", 32'(fetch_rdata), 32'(ref_mem[0]));
    step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step();
      if (!fetch_req || last_f_gnt) begin
        fetch_req  = ($urandom_range(0, 9) < 7);
        fetch_addr = AW'($urandom_range(0, 63));
      end
      if (!ld_req || last_l_gnt) begin
        ld_req   = ($urandom_range(0, 9) < 5);
        ld_we    = 1'($urandom_range(0, 1));
        ld_addr  = AW'($urandom_range(0, 63));
        ld_wdata = 16'($urandom);
      end
    end

    fetch_req = 1'b0; ld_req = 1'b0;
    repeat (3) step();
    chk("fq_drained", 32'(fq.size()), 32'd0);
    chk("lq_drained", 32'(lq.size()), 32'd0);
    chk("errq_drained", 32'(errq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
